vga_timing_core: RTL and testbench

//  Parameterised VGA raster timing generator. Produces hpos/vpos, hsync/vsync,

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_core.sv | 125 ++++++++++++
 tb/tb_vga_timing_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  function automatic int total(
    input int active,
    input int front,
    input int sync,
    input int back
  );
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus active/sync decodes.
// Decodes look at the next position so the caller can register them in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             active,
  output logic             sync_window
);

  localparam int TOTAL = total(ACTIVE, FRONT, SYNC, BACK);

  localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] ACT_END = POS_W'(ACTIVE - 1);
  localparam logic [POS_W-1:0] S_BEG   = POS_W'(ACTIVE + FRONT);
  localparam logic [POS_W-1:0] S_END   = POS_W'(ACTIVE + FRONT + SYNC - 1);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  assign wrap = (pos_q == LAST);

  always_comb begin
    pos_d = pos_q;
    if (advance) begin
      pos_d = wrap ? '0 : pos_q + 1'b1;
    end
  end

  assign active      = (pos_d <= ACT_END);
  assign sync_window = (pos_d >= S_BEG) && (pos_d <= S_END);

  // Reset parks on the last position so the first advance lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= LAST;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator: counters, syncs, blanking and strobes.
// Every output is a flop describing the same (hpos, vpos) pixel.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_no
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_core: raster total exceeds counter range");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("vga_timing_core: sync width must be non-zero");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
    $error("vga_timing_core: active region must be non-zero");
  end

  logic h_wrap, h_act, h_sync_win;
  logic v_wrap, v_act, v_sync_win;
  logic v_adv;

  assign v_adv = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (pix_en),
    .pos         (hpos),
    .wrap        (h_wrap),
    .active      (h_act),
    .sync_window (h_sync_win)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (v_adv),
    .pos         (vpos),
    .wrap        (v_wrap),
    .active      (v_act),
    .sync_window (v_sync_win)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               disp_q, disp_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [FRAME_W-1:0] fno_q, fno_d;

  always_comb begin
    hsync_d = h_sync_win ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = v_sync_win ? VSYNC_POL : ~VSYNC_POL;
    disp_d  = h_act & v_act;
    ls_d    = v_adv;
    fs_d    = v_adv & v_wrap;
    fno_d   = fno_q;
    if (fs_d) begin
      fno_d = fno_q + 1'b1;
    end
  end

  // frame_no resets to all-ones so the first frame_start reads as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      disp_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fno_q   <= '1;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fno_q   <= fno_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_no    = fno_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: default 640x480 instance for line timing,
// tiny 8x4 instance for frame, enable-gating and frame_no wrap.
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [8:0] frame_no;

  logic [9:0] s_hpos, s_vpos;
  logic       s_hsync, s_vsync, s_disp, s_ls, s_fs;
  logic [8:0] s_fno;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_no    (frame_no)
  );

  vga_timing_core #(
    .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_ACTIVE (1), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .FRAME_W  (9)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_disp),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_no    (s_fno)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_en = 1'b1;
    repeat (5) step();
    checks++;
    if (hpos !== 10'd799 || vpos !== 10'd524) begin
      failures++;
      $display("FAIL rst_pos got (%0d,%0d) want (799,524)", hpos, vpos);
    end
    checks++;
    if ({display_on, hsync, vsync, line_start, frame_start} !== 5'b01100) begin
      failures++;
      $display("FAIL rst_flags got %b want 01100",
               {display_on, hsync, vsync, line_start, frame_start});
    end
    checks++;
    if (frame_no !== 9'd511) begin
      failures++;
      $display("FAIL rst_frame_no got %0d want 511", frame_no);
    end
    checks++;
    if (s_hpos !== 10'd7 || s_vpos !== 10'd3) begin
      failures++;
      $display("FAIL rst_small_pos got (%0d,%0d) want (7,3)", s_hpos, s_vpos);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (hpos !== 10'd0 || vpos !== 10'd0) begin
      failures++;
      $display("FAIL first_pos got (%0d,%0d) want (0,0)", hpos, vpos);
    end
    checks++;
    if ({display_on, line_start, frame_start} !== 3'b111) begin
      failures++;
      $display("FAIL first_flags got %b want 111",
               {display_on, line_start, frame_start});
    end
    checks++;
    if (frame_no !== 9'd0) begin
      failures++;
      $display("FAIL first_frame_no got %0d want 0", frame_no);
    end
  endtask

  task automatic test_line0();
    for (int h = 0; h < 800; h++) begin
      logic exp_d, exp_hs, exp_ls;
      exp_d  = (h < 640);
      exp_hs = !(h >= 656 && h <= 751);
      exp_ls = (h == 0);
      checks++;
      if (hpos !== 10'(h) || vpos !== 10'd0) begin
        failures++;
        $display("FAIL line0_pos got (%0d,%0d) want (%0d,0)", hpos, vpos, h);
      end
      checks++;
      if (display_on !== exp_d) begin
        failures++;
        $display("FAIL line0_disp h=%0d got %b want %b", h, display_on, exp_d);
      end
      checks++;
      if (hsync !== exp_hs) begin
        failures++;
        $display("FAIL line0_hsync h=%0d got %b want %b", h, hsync, exp_hs);
      end
      checks++;
      if (line_start !== exp_ls) begin
        failures++;
        $display("FAIL line0_ls h=%0d got %b want %b", h, line_start, exp_ls);
      end
      step();
    end
  endtask

  task automatic test_line_wrap();
    checks++;
    if (hpos !== 10'd0 || vpos !== 10'd1) begin
      failures++;
      $display("FAIL wrap_pos got (%0d,%0d) want (0,1)", hpos, vpos);
    end
    checks++;
    if ({line_start, frame_start, display_on} !== 3'b101) begin
      failures++;
      $display("FAIL wrap_flags got %b want 101",
               {line_start, frame_start, display_on});
    end
  endtask

  task automatic test_mid_reset();
    repeat (300) step();
    checks++;
    if (hpos !== 10'd300 || vpos !== 10'd1) begin
      failures++;
      $display("FAIL mid_pre got (%0d,%0d) want (300,1)", hpos, vpos);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hpos !== 10'd799 || vpos !== 10'd524 || frame_no !== 9'd511) begin
      failures++;
      $display("FAIL mid_async got (%0d,%0d,%0d) want (799,524,511)",
               hpos, vpos, frame_no);
    end
    checks++;
    if ({display_on, hsync, vsync, line_start} !== 4'b0110) begin
      failures++;
      $display("FAIL mid_async_flags got %b want 0110",
               {display_on, hsync, vsync, line_start});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (hpos !== 10'd0 || vpos !== 10'd0 || frame_no !== 9'd0) begin
      failures++;
      $display("FAIL mid_restart got (%0d,%0d,%0d) want (0,0,0)",
               hpos, vpos, frame_no);
    end
    checks++;
    if ({line_start, frame_start, display_on} !== 3'b111) begin
      failures++;
      $display("FAIL mid_restart_flags got %b want 111",
               {line_start, frame_start, display_on});
    end
    checks++;
    if (s_hpos !== 10'd0 || s_vpos !== 10'd0 || s_fno !== 9'd0) begin
      failures++;
      $display("FAIL mid_small got (%0d,%0d,%0d) want (0,0,0)",
               s_hpos, s_vpos, s_fno);
    end
  endtask

  task automatic test_frames();
    int last_fs = -1;
    for (int c = 0; c <= 64; c++) begin
      int h, v;
      h = c % 8;
      v = (c / 8) % 4;
      checks++;
      if (s_hpos !== 10'(h) || s_vpos !== 10'(v)) begin
        failures++;
        $display("FAIL frm_pos c=%0d got (%0d,%0d) want (%0d,%0d)",
                 c, s_hpos, s_vpos, h, v);
      end
      checks++;
      if (s_vsync !== (v != 2) || s_hsync !== !(h == 5 || h == 6)) begin
        failures++;
        $display("FAIL frm_sync c=%0d got hs=%b vs=%b", c, s_hsync, s_vsync);
      end
      checks++;
      if (s_disp !== (h < 4 && v == 0)) begin
        failures++;
        $display("FAIL frm_disp c=%0d got %b", c, s_disp);
      end
      checks++;
      if (s_fs !== (c % 32 == 0) || s_fno !== 9'(c / 32)) begin
        failures++;
        $display("FAIL frm_fs c=%0d got fs=%b fno=%0d want fs=%b fno=%0d",
                 c, s_fs, s_fno, (c % 32 == 0), c / 32);
      end
      checks++;
      if (vsync !== 1'b1) begin
        failures++;
        $display("FAIL frm_big_vsync c=%0d got %b want 1", c, vsync);
      end
      if (s_fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (c - last_fs != 32) begin
            failures++;
            $display("FAIL frm_interval got %0d want 32", c - last_fs);
          end
        end
        last_fs = c;
      end
      if (c < 64) step();
    end
  endtask

  task automatic test_pix_en_toggle();
    int mh = 0;
    int mv = 0;
    int mf = 2;
    int last_fs = -1;
    for (int i = 0; i < 128; i++) begin
      logic en, els, efs;
      en = (i % 2 == 0);
      pix_en = en;
      step();
      els = 1'b0;
      efs = 1'b0;
      if (en) begin
        mh = (mh + 1) % 8;
        if (mh == 0) begin
          mv = (mv + 1) % 4;
          els = 1'b1;
          if (mv == 0) begin
            efs = 1'b1;
            mf = (mf + 1) % 512;
          end
        end
      end
      checks++;
      if (s_hpos !== 10'(mh) || s_vpos !== 10'(mv) || s_fno !== 9'(mf)) begin
        failures++;
        $display("FAIL tog_pos i=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, s_hpos, s_vpos, s_fno, mh, mv, mf);
      end
      checks++;
      if (s_ls !== els || s_fs !== efs) begin
        failures++;
        $display("FAIL tog_strobe i=%0d got ls=%b fs=%b want ls=%b fs=%b",
                 i, s_ls, s_fs, els, efs);
      end
      checks++;
      if (s_hsync !== !(mh == 5 || mh == 6) || s_disp !== (mh < 4 && mv == 0)) begin
        failures++;
        $display("FAIL tog_flags i=%0d got hs=%b disp=%b", i, s_hsync, s_disp);
      end
      if (s_fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != 64) begin
            failures++;
            $display("FAIL tog_interval got %0d want 64", i - last_fs);
          end
        end
        last_fs = i;
      end
    end
    pix_en = 1'b1;
  endtask

  task automatic test_frame_wrap();
    logic seen_wrap = 1'b0;
    logic [8:0] prev;
    prev = s_fno;
    for (int f = 1; f <= 512; f++) begin
      repeat (32) step();
      checks++;
      if (s_fs !== 1'b1 || s_fno !== 9'((4 + f) % 512)) begin
        failures++;
        $display("FAIL wrap_fno f=%0d got fs=%b fno=%0d want fs=1 fno=%0d",
                 f, s_fs, s_fno, (4 + f) % 512);
      end
      if (prev == 9'd511 && s_fno == 9'd0) seen_wrap = 1'b1;
      prev = s_fno;
    end
    checks++;
    if (seen_wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_seen got %b want 1", seen_wrap);
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_line_wrap();
    test_mid_reset();
    test_frames();
    test_pix_en_toggle();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
